rtype_sequencer: RTL and testbench
==================================

RTYPE_SEQUENCER -- requirements
Module: rtype_sequencer

Interface
REQ-001 SHALL have port clock  input  1  sole clock; all state changes on rising edge.
REQ-002 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port instr_valid  input  1  an instruction is offered on instruction.
REQ-004 SHALL have port instruction  input  32  MIPS R-type word: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], func[5:0].
REQ-005 SHALL have port instr_ready  output  1  sequencer accepts instruction this cycle.
REQ-006 SHALL have port stall  input  1  freezes the FSM and all registers while high.
REQ-007 SHALL have port rs_addr, rt_addr, rd_addr  output  5 each  register-file addresses, registered.
REQ-008 SHALL have port alu_op  output  3  ALU operation code, registered.
REQ-009 SHALL have port reg_we  output  1  register-file write enable, one-cycle pulse.
REQ-010 SHALL have port done  output  1  one-cycle pulse when an instruction retires or is rejected.
REQ-011 SHALL have port illegal  output  1  qualifies done: instruction was rejected.
REQ-012 SHALL have port retired_count  output  16  count of instructions retired with reg_we.

Function
REQ-013 SHALL implement FSM states IDLE, DECODE, EXEC, WB.
REQ-014 In IDLE, instr_ready SHALL be 1; other states drive 0; stall high forces instr_ready 0.
REQ-015 A transfer SHALL occur on an edge where instr_valid and instr_ready are both 1; the instruction is captured into an internal register and the FSM enters DECODE.
REQ-016 DECODE SHALL drive rs_addr, rt_addr, rd_addr from the captured word and compute alu_op; next state EXEC if legal, otherwise IDLE with done=1 and illegal=1 on that transition.
REQ-017 Legal SHALL mean opcode==0 and func in {0x20 add->010, 0x22 sub->110, 0x24 and->000, 0x25 or->001, 0x2A slt->111}; any other func or nonzero opcode is illegal.
REQ-018 EXEC SHALL hold all addresses and alu_op stable for one cycle (ALU settle), then move to WB.
REQ-019 WB SHALL assert reg_we=1 for exactly one cycle unless rd==0, in which case reg_we stays 0; done=1 in the same cycle; next state IDLE.
REQ-020 retired_count SHALL increment by 1 on each WB cycle with reg_we=1, wrapping 0xFFFF->0x0000; rd==0 and illegal instructions do not count.
REQ-021 Legal-instruction latency SHALL be 4 cycles from the accepting edge to the reg_we/done edge, i.e. accept, DECODE, EXEC, WB, giving a maximum throughput of one instruction per 4 cycles.
REQ-022 While stall=1 the FSM, captured instruction, addresses, alu_op and retired_count SHALL hold; reg_we and done SHALL be 0; the pending action resumes in the first cycle after stall falls.
REQ-023 instruction changes while not in IDLE SHALL have no effect.
REQ-024 rs_addr, rt_addr, rd_addr and alu_op SHALL keep their last values in IDLE.

Reset
REQ-025 reset_n low SHALL immediately force state IDLE, all address outputs 0, alu_op 000, reg_we 0, done 0, illegal 0, retired_count 0, independent of clock.
REQ-026 A reset asserted mid-instruction SHALL abort it with no reg_we pulse and no count update.
REQ-027 instr_ready SHALL be 1 in the first cycle after reset_n rises, unless stall is high.

Verification
REQ-028 Add: instruction 0x00221820 (add $3,$1,$2) -> rs=1, rt=2, rd=3, alu_op=010, reg_we and done high exactly 4 cycles after accept, retired_count=1.
REQ-029 Illegal: opcode 0x23 or func 0x27 -> done=1, illegal=1 one cycle after accept, reg_we never asserted, count unchanged.
REQ-030 rd==0: 0x00220024 (and $0,$1,$2) -> done in WB, reg_we=0, count unchanged.
REQ-031 Stall: stall high for 3 cycles during EXEC -> reg_we arrives 3 cycles later than the 4-cycle latency of REQ-021; outputs stable throughout.
REQ-032 Back-to-back: instr_valid held high with sub (func 0x22) then slt (func 0x2A) -> accepts 4 cycles apart, alu_op 110 then 111, two reg_we pulses.
REQ-033 Reset mid-EXEC -> outputs zero asynchronously, no reg_we, instr_ready=1 in the first cycle after release; retired_count wraps from 0xFFFF to 0 after one further retire.

Source files
------------

// File: rtl/rtype_sequencer.sv
// rtype_sequencer: four-state (IDLE/DECODE/EXEC/WB) sequencer for MIPS R-type ALU instructions.
// Control pulses are decoded from the registered state and forced low while stall is high.
module rtype_sequencer (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        instr_valid,
  input  logic [31:0] instruction,
  output logic        instr_ready,
  input  logic        stall,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  output logic [4:0]  rd_addr,
  output logic [2:0]  alu_op,
  output logic        reg_we,
  output logic        done,
  output logic        illegal,
  output logic [15:0] retired_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_instr;
  logic [4:0]  r_rs_addr;
  logic [4:0]  r_rt_addr;
  logic [4:0]  r_rd_addr;
  logic [2:0]  r_alu_op;
  logic [15:0] r_retired_count;
  logic        w_accept;
  logic        w_load_decode;
  logic        w_retire;
  logic        w_legal;
  logic [2:0]  w_dec_op;
  logic        w_unused_shamt;

  // Returns {legal, alu_op}; anything outside the five supported ALU functions is illegal.
  function automatic logic [3:0] decode_func(input logic [5:0] opcode, input logic [5:0] func);
    logic [3:0] res;
    res = 4'b0000;
    if (opcode != 6'd0) begin
      res = 4'b0000;
    end else begin
      case (func)
        6'h20:   res = 4'b1010;
        6'h22:   res = 4'b1110;
        6'h24:   res = 4'b1000;
        6'h25:   res = 4'b1001;
        6'h2A:   res = 4'b1111;
        default: res = 4'b0000;
      endcase
    end
    return res;
  endfunction

  assign w_unused_shamt = ^r_instr[10:6];

  always_comb begin
    w_next_state  = r_state;
    instr_ready   = 1'b0;
    reg_we        = 1'b0;
    done          = 1'b0;
    illegal       = 1'b0;
    w_accept      = 1'b0;
    w_load_decode = 1'b0;
    w_retire      = 1'b0;
    {w_legal, w_dec_op} = decode_func(r_instr[31:26], r_instr[5:0]);
    if (!stall) begin
      case (r_state)
        IDLE: begin
          instr_ready = 1'b1;
          if (instr_valid) begin
            w_accept     = 1'b1;
            w_next_state = DECODE;
          end else begin
            w_next_state = IDLE;
          end
        end
        DECODE: begin
          w_load_decode = 1'b1;
          if (w_legal) begin
            w_next_state = EXEC;
          end else begin
            w_next_state = IDLE;
            done         = 1'b1;
            illegal      = 1'b1;
          end
        end
        EXEC: begin
          w_next_state = WB;
        end
        WB: begin
          // Writes to $0 retire without a register-file write and are not counted.
          w_retire     = (r_rd_addr != 5'd0);
          reg_we       = w_retire;
          done         = 1'b1;
          w_next_state = IDLE;
        end
        default: begin
          w_next_state = IDLE;
        end
      endcase
    end else begin
      w_next_state = r_state;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_instr <= 32'd0;
    end else if (w_accept) begin
      r_instr <= instruction;
    end
  end

  // Addresses follow every decoded word; alu_op keeps its last value when the word is illegal.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rs_addr <= 5'd0;
      r_rt_addr <= 5'd0;
      r_rd_addr <= 5'd0;
      r_alu_op  <= 3'b000;
    end else if (w_load_decode) begin
      r_rs_addr <= r_instr[25:21];
      r_rt_addr <= r_instr[20:16];
      r_rd_addr <= r_instr[15:11];
      if (w_legal) begin
        r_alu_op <= w_dec_op;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_retired_count <= 16'd0;
    end else if (w_retire) begin
      r_retired_count <= r_retired_count + 16'd1;
    end
  end

  assign rs_addr       = r_rs_addr;
  assign rt_addr       = r_rt_addr;
  assign rd_addr       = r_rd_addr;
  assign alu_op        = r_alu_op;
  assign retired_count = r_retired_count;

endmodule

// File: tb/tb_rtype_sequencer.sv
// Self-checking bench for rtype_sequencer: directed scenarios plus random traffic against a
// transaction-level model that tracks unstalled cycles elapsed since each accepted instruction.
`timescale 1ns/1ps
module tb_rtype_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instruction = 32'd0;
  logic        stall = 1'b0;
  logic        instr_ready;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [4:0]  rd_addr;
  logic [2:0]  alu_op;
  logic        reg_we;
  logic        done;
  logic        illegal;
  logic [15:0] retired_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  rtype_sequencer dut (
    .clock(clock), .reset_n(reset_n), .instr_valid(instr_valid), .instruction(instruction),
    .instr_ready(instr_ready), .stall(stall), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rd_addr(rd_addr), .alu_op(alu_op), .reg_we(reg_we), .done(done), .illegal(illegal),
    .retired_count(retired_count)
  );

  // {instr_ready, reg_we, done, illegal, rs, rt, rd, alu_op, retired_count}
  wire [37:0] w_obs = {instr_ready, reg_we, done, illegal, rs_addr, rt_addr, rd_addr, alu_op, retired_count};
  localparam logic [37:0] RESET_VEC = {1'b1, 37'd0};

  logic [5:0]  leg_func [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  logic [2:0]  leg_op   [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

  // Model: m_age = unstalled cycles since acceptance (-1 when free).
  int          m_age;
  logic [31:0] m_ins;
  logic [4:0]  m_rs, m_rt, m_rd;
  logic [2:0]  m_op;
  logic [15:0] m_count;
  logic [37:0] exp_vec;

  function automatic int op_index(input logic [31:0] w);
    int r;
    r = -1;
    if (w[31:26] == 6'd0)
      for (int i = 0; i < 5; i++) if (leg_func[i] == w[5:0]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_age = -1; m_ins = 32'd0; m_rs = 5'd0; m_rt = 5'd0; m_rd = 5'd0; m_op = 3'd0; m_count = 16'd0;
  endtask

  // Drives one cycle of inputs, forms this cycle's expected outputs and advances the model.
  task automatic cyc(input logic v, input logic [31:0] ins, input logic st);
    int   idx;
    logic e_rdy, e_we, e_done, e_ill;
    @(negedge clock);
    instr_valid = v; instruction = ins; stall = st;
    idx = op_index(m_ins);
    e_rdy = (m_age < 0) && !st;
    e_we = 1'b0; e_done = 1'b0; e_ill = 1'b0;
    if (!st && m_age == 1 && idx < 0) begin e_done = 1'b1; e_ill = 1'b1; end
    if (!st && m_age == 3) begin e_done = 1'b1; e_we = (m_rd != 5'd0); end
    exp_vec = {e_rdy, e_we, e_done, e_ill, m_rs, m_rt, m_rd, m_op, m_count};
    if (!st) begin
      if (m_age < 0) begin
        if (v) begin m_age = 1; m_ins = ins; end
      end else if (m_age == 1) begin
        m_rs = m_ins[25:21]; m_rt = m_ins[20:16]; m_rd = m_ins[15:11];
        if (idx >= 0) begin m_op = leg_op[idx]; m_age = 2; end
        else m_age = -1;
      end else if (m_age == 2) begin
        m_age = 3;
      end else begin
        if (e_we) m_count = m_count + 16'd1;
        m_age = -1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; instr_valid = 1'b0; stall = 1'b0; instruction = 32'd0;
    @(negedge clock); #1;
    n_cmp++;
    if (w_obs !== RESET_VEC) begin n_bad++; $display("FAIL reset_values: got %h want %h", w_obs, RESET_VEC); end
    reset_n = 1'b1;
    model_reset();
    cyc(1'b0, 32'd0, 1'b0);
    n_cmp++;
    if (instr_ready !== 1'b1 || w_obs !== exp_vec) begin
      n_bad++; $display("FAIL ready_after_reset: got %h want %h", w_obs, exp_vec);
    end
    cyc(1'b1, 32'h00221820, 1'b1);
    n_cmp++;
    if (instr_ready !== 1'b0 || w_obs !== exp_vec) begin
      n_bad++; $display("FAIL stall_blocks_ready: got %h want %h", w_obs, exp_vec);
    end
  endtask

  task automatic test_add();
    int lat;
    lat = 0;
    cyc(1'b1, 32'h00221820, 1'b0);
    n_cmp++;
    if (w_obs !== exp_vec) begin n_bad++; $display("FAIL add_accept: got %h want %h", w_obs, exp_vec); end
    for (int k = 1; k <= 6; k++) begin
      cyc(1'b0, $urandom, 1'b0);
      n_cmp++;
      if (w_obs !== exp_vec) begin n_bad++; $display("FAIL add_seq[%0d]: got %h want %h", k, w_obs, exp_vec); end
      if (reg_we === 1'b1 && lat == 0) lat = k + 1;
    end
    n_cmp++;
    if (lat !== 4) begin n_bad++; $display("FAIL add_latency: got %0d want 4", lat); end
    n_cmp++;
    if ({rs_addr, rt_addr, rd_addr, alu_op, retired_count} !== {5'd1, 5'd2, 5'd3, 3'b010, 16'd1}) begin
      n_bad++;
      $display("FAIL add_fields: got rs=%0d rt=%0d rd=%0d op=%b cnt=%0d want 1 2 3 010 1",
               rs_addr, rt_addr, rd_addr, alu_op, retired_count);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] words [2];
    words[0] = 32'h8C221820;
    words[1] = 32'h00221827;
    for (int w = 0; w < 2; w++) begin
      cyc(1'b1, words[w], 1'b0);
      n_cmp++;
      if (w_obs !== exp_vec) begin n_bad++; $display("FAIL illegal_accept[%0d]: got %h want %h", w, w_obs, exp_vec); end
      cyc(1'b0, 32'h00221820, 1'b0);
      n_cmp++;
      if ({done, illegal, reg_we} !== 3'b110 || w_obs !== exp_vec) begin
        n_bad++; $display("FAIL illegal_done[%0d]: got %h want %h", w, w_obs, exp_vec);
      end
      for (int k = 0; k < 3; k++) begin
        cyc(1'b0, 32'd0, 1'b0);
        n_cmp++;
        if (reg_we !== 1'b0 || w_obs !== exp_vec) begin
          n_bad++; $display("FAIL illegal_after[%0d]: got %h want %h", w, w_obs, exp_vec);
        end
      end
    end
  endtask

  task automatic test_rd_zero();
    cyc(1'b1, 32'h00220024, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      cyc(1'b0, 32'd0, 1'b0);
      n_cmp++;
      if (w_obs !== exp_vec) begin n_bad++; $display("FAIL rd_zero_seq[%0d]: got %h want %h", k, w_obs, exp_vec); end
      if (k == 3) begin
        n_cmp++;
        if ({done, reg_we} !== 2'b10) begin n_bad++; $display("FAIL rd_zero_wb: got done=%b we=%b want 1 0", done, reg_we); end
      end
    end
  endtask

  task automatic test_stall();
    int lat;
    lat = 0;
    cyc(1'b1, 32'h00853022, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      cyc(1'b0, $urandom, (k >= 2 && k <= 4));
      n_cmp++;
      if (w_obs !== exp_vec) begin n_bad++; $display("FAIL stall_seq[%0d]: got %h want %h", k, w_obs, exp_vec); end
      if (reg_we === 1'b1 && lat == 0) lat = k + 1;
    end
    n_cmp++;
    if (lat !== 7) begin n_bad++; $display("FAIL stall_latency: got %0d want 7", lat); end
  endtask

  task automatic test_back_to_back();
    int acc [$];
    int pulses;
    logic [2:0] op_a, op_b;
    pulses = 0; op_a = 3'bxxx; op_b = 3'bxxx;
    for (int k = 0; k < 10; k++) begin
      cyc(k < 8, (k < 4) ? 32'h00431022 : 32'h00A4382A, 1'b0);
      n_cmp++;
      if (w_obs !== exp_vec) begin n_bad++; $display("FAIL b2b_seq[%0d]: got %h want %h", k, w_obs, exp_vec); end
      if (instr_ready === 1'b1 && instr_valid === 1'b1) acc.push_back(k);
      if (reg_we === 1'b1) pulses++;
      if (k == 2) op_a = alu_op;
      if (k == 6) op_b = alu_op;
    end
    n_cmp++;
    if (acc.size() != 2 || acc[0] != 0 || acc[1] != 4) begin
      n_bad++; $display("FAIL b2b_accepts: got %0d accepts want 2 at cycles 0 and 4", acc.size());
    end
    n_cmp++;
    if ({op_a, op_b} !== {3'b110, 3'b111} || pulses != 2) begin
      n_bad++; $display("FAIL b2b_ops: got ops %b %b pulses %0d want 110 111 2", op_a, op_b, pulses);
    end
  endtask

  task automatic test_reset_mid_and_wrap();
    cyc(1'b1, 32'h00221820, 1'b0);
    cyc(1'b0, 32'd0, 1'b0);
    cyc(1'b0, 32'd0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (w_obs !== RESET_VEC) begin n_bad++; $display("FAIL reset_async: got %h want %h", w_obs, RESET_VEC); end
    @(posedge clock); #1;
    n_cmp++;
    if (w_obs !== RESET_VEC) begin n_bad++; $display("FAIL reset_hold: got %h want %h", w_obs, RESET_VEC); end
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 32'd0, 1'b0);
      n_cmp++;
      if (instr_ready !== 1'b1 || reg_we !== 1'b0 || w_obs !== exp_vec) begin
        n_bad++; $display("FAIL reset_release[%0d]: got %h want %h", k, w_obs, exp_vec);
      end
    end
    force dut.r_retired_count = 16'hFFFF;
    #1;
    release dut.r_retired_count;
    m_count = 16'hFFFF;
    cyc(1'b1, 32'h00221820, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      cyc(1'b0, 32'd0, 1'b0);
      n_cmp++;
      if (w_obs !== exp_vec) begin n_bad++; $display("FAIL wrap_seq[%0d]: got %h want %h", k, w_obs, exp_vec); end
    end
    n_cmp++;
    if (retired_count !== 16'h0000) begin n_bad++; $display("FAIL count_wrap: got %h want 0000", retired_count); end
  endtask

  task automatic test_random();
    logic [31:0] w;
    int r;
    for (int k = 0; k < 600; k++) begin
      r = $urandom_range(0, 9);
      if (r < 6) w = {6'd0, 5'($urandom), 5'($urandom), 5'($urandom_range(0, 7)), 5'($urandom), leg_func[$urandom_range(0, 4)]};
      else if (r < 8) w = {6'd0, 20'($urandom), 6'($urandom)};
      else w = $urandom;
      cyc($urandom_range(0, 9) < 6, w, $urandom_range(0, 9) < 2);
      n_cmp++;
      if (w_obs !== exp_vec) begin n_bad++; $display("FAIL random[%0d]: got %h want %h", k, w_obs, exp_vec); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_add();
    test_illegal();
    test_rd_zero();
    test_stall();
    test_back_to_back();
    test_random();
    test_reset_mid_and_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
